// File: rtl/aes_mix_columns_serial.sv
// aes_mix_columns_serial
//   Column-serial AES MixColumns / InvMixColumns over a 128-bit state.
//   One column is transformed per cycle by a single aes_mix_single_column
//   instance, so a full state takes four RUN cycles.
//
//   Ports:
//     clk_i        rising-edge clock
//     rst_i        asynchronous active-high reset
//     op_i         0 = MixColumns, 1 = InvMixColumns (sampled at accept)
//     in_valid_i   input state valid
//     in_ready_o   block idle, can accept a state
//     data_i       input state, byte (r,c) at [((r*4)+c)*8 +: 8]
//     out_valid_o  result valid
//     out_ready_i  downstream accepts the result
//     data_o       result state (zero while out_valid_o is low)
//     abort_i      synchronous abort, highest priority
//     busy_o       FSM not idle
//
//   Parameter CLEAR_ON_DONE: zero the state register on output handshake.

module aes_mix_single_column (
  input  logic        op_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant: sum of the doubled terms
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return (k[0] ? a : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = data_i[7:0];
    a1 = data_i[15:8];
    a2 = data_i[23:16];
    a3 = data_i[31:24];
    data_o = '0;
    if (!op_i) begin
      data_o[7:0]   = gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3;
      data_o[15:8]  = a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3;
      data_o[23:16] = a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3);
      data_o[31:24] = gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2);
    end else begin
      data_o[7:0]   = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      data_o[15:8]  = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      data_o[23:16] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      data_o[31:24] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
    end
  end

endmodule

module aes_mix_columns_serial #(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o,
  input  logic         abort_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  st_q, st_d;
  logic          op_q, op_d;
  logic [1:0]    col_q, col_d;
  logic [31:0]   col_in, col_out;

  // Gather column col_q: row r byte goes to instance byte r
  always_comb begin
    col_in = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col_in[r*8 +: 8] = st_q[(r*4 + 32'(col_q))*8 +: 8];
    end
  end

  aes_mix_single_column u_mix (
    .op_i   (op_q),
    .data_i (col_in),
    .data_o (col_out)
  );

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    op_d    = op_q;
    col_d   = col_q;
    if (abort_i) begin
      state_d = IDLE;
      st_d    = '0;
      col_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            st_d    = data_i;
            op_d    = op_i;
            col_d   = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          for (int unsigned r = 0; r < 4; r++) begin
            st_d[(r*4 + 32'(col_q))*8 +: 8] = col_out[r*8 +: 8];
          end
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) state_d = DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            state_d = IDLE;
            if (CLEAR_ON_DONE) st_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      st_q    <= '0;
      op_q    <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      op_q    <= op_d;
      col_q   <= col_d;
    end
  end

  // Outputs are decoded from state only, so an async reset shows immediately
  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign data_o      = (state_q == DONE) ? st_q : '0;

endmodule
